// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with shadowed display value,
// anode dead-time at the start of each slot, and leading-zero blanking.

// One digit's leading-zero lane: extends the "all zero from the top" chain
// and decides whether this digit is blanked.
module seg7_lz_lane (
  input  logic [3:0] nib,
  input  logic       zero_above,
  input  logic       lz_blank,
  output logic       zero_here,
  output logic       blank
);
  assign zero_here = zero_above && (nib == 4'h0);
  assign blank     = lz_blank && zero_here;
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                cnt;
  logic [NUM_DIGITS-1:0][3:0]      val_sh;
  logic [NUM_DIGITS-1:0]           dp_sh, en_sh;
  logic [NUM_DIGITS-1:0]           blank;
  logic [NUM_DIGITS:1]             zero_chain;
  logic                            slot_active, lit;
  logic [3:0]                      nib;
  logic [NUM_DIGITS-1:0]           an_d;
  logic [6:0]                      seg_d;
  logic                            dp_d;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
      4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
      4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
      4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
    endcase
  endfunction

  // Zero chain runs from the top digit down; digit 0 is never blanked.
  assign zero_chain[NUM_DIGITS] = 1'b1;
  assign blank[0] = 1'b0;
  for (genvar g = NUM_DIGITS - 1; g >= 1; g--) begin : g_lane
    logic zero_here;
    seg7_lz_lane u_lane (
      .nib        (val_sh[g]),
      .zero_above (zero_chain[g+1]),
      .lz_blank   (lz_blank),
      .zero_here  (zero_here),
      .blank      (blank[g])
    );
    if (g > 1) begin : g_link
      assign zero_chain[g] = zero_here;
    end else begin : g_tail
      assign zero_chain[1] = 1'b1 & zero_here;
    end
  end

  // Dead-time window at the head of each slot.
  if (GUARD_CYCLES == 0) begin : g_noguard
    assign slot_active = 1'b1;
  end else begin : g_guard
    assign slot_active = (cnt >= CNT_W'(GUARD_CYCLES));
  end

  assign nib = val_sh[digit_idx];
  assign lit = slot_active && en_sh[digit_idx] && !blank[digit_idx];

  // Prescaler and scan index; frame_tick marks the last-digit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else if (cnt == LAST_CNT) begin
      cnt        <= '0;
      digit_idx  <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      frame_tick <= (digit_idx == LAST_IDX);
    end else begin
      cnt        <= cnt + 1'b1;
      frame_tick <= 1'b0;
    end
  end

  // Shadow copy of the display contents, updated on load at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_sh <= '0;
      dp_sh  <= '0;
      en_sh  <= '0;
    end else if (load) begin
      val_sh <= value_in;
      dp_sh  <= dp_in;
      en_sh  <= digit_en;
    end
  end

  // Next pin values for the current digit; dark when not lit.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[digit_idx] = 1'b0;
      seg_d = ~font(nib);
      dp_d  = ~dp_sh[digit_idx];
    end
  end

  // Registered, active-low pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit instance and a 1-digit no-guard
// instance run in lockstep against a time-index reference model.
module tb_seg7_scan_driver;
  localparam int N = 4, DIV = 8, G = 2;

  logic        clk = 1'b0;
  logic        rst, load, lz_blank;
  logic [15:0] value_in;
  logic [3:0]  dp_in, digit_en;
  logic [6:0]  seg, seg1;
  logic        dp, dp1, frame_tick, ft1;
  logic [3:0]  an;
  logic [0:0]  an1, idx1;
  logic [1:0]  digit_idx;

  int checks = 0, errors = 0;
  int k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0, m_en = '0;
  logic        m_en1 = 1'b0;
  logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .digit_idx(digit_idx), .frame_tick(frame_tick));

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(DIV), .GUARD_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in[3:0]), .dp_in(dp_in[0]),
    .digit_en(1'b1), .lz_blank(lz_blank), .seg(seg1), .dp(dp1), .an(an1),
    .digit_idx(idx1), .frame_tick(ft1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // One clock edge: predict pins from the model, apply the edge, compare.
  task automatic step(input logic ld, input logic rs);
    logic [3:0] e_an;  logic [6:0] e_seg;  logic e_dp;  logic [1:0] e_idx;  logic e_ft;
    logic [0:0] e_an1; logic [6:0] e_seg1; logic e_dp1; logic e_ft1;
    int pos, d;
    logic lit;
    load = ld;
    rst  = rs;
    if (rs) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_ft = 1'b0;
      e_an1 = 1'b1; e_seg1 = 7'h7F; e_dp1 = 1'b1; e_ft1 = 1'b0;
    end else begin
      pos = k % DIV;
      d   = (k / DIV) % N;
      lit = (pos >= G) && m_en[d] && !(lz_blank && d != 0 && (m_val >> (4 * d)) == 16'h0);
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit ? ~font[m_val[4*d +: 4]] : 7'h7F;
      e_dp  = lit ? ~m_dp[d] : 1'b1;
      e_idx = 2'(((k + 1) / DIV) % N);
      e_ft  = (k % (DIV * N)) == (DIV * N - 1);
      e_an1  = m_en1 ? 1'b0 : 1'b1;
      e_seg1 = m_en1 ? ~font[m_val[3:0]] : 7'h7F;
      e_dp1  = m_en1 ? ~m_dp[0] : 1'b1;
      e_ft1  = (k % DIV) == (DIV - 1);
    end
    if (rs) begin
      k = 0; m_val = '0; m_dp = '0; m_en = '0; m_en1 = 1'b0;
    end else begin
      k++;
      if (ld) begin
        m_val = value_in; m_dp = dp_in; m_en = digit_en; m_en1 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("idx", 16'(digit_idx), 16'(e_idx));
    chk("frame_tick", 16'(frame_tick), 16'(e_ft));
    chk("an1", 16'(an1), 16'(e_an1));
    chk("seg1", 16'(seg1), 16'(e_seg1));
    chk("dp1", 16'(dp1), 16'(e_dp1));
    chk("idx1", 16'(idx1), 16'd0);
    chk("frame_tick1", 16'(ft1), 16'(e_ft1));
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_blank = 1'b0;
    value_in = '0; dp_in = '0; digit_en = '0;
    @(negedge clk);
    repeat (2) step(1'b0, 1'b1);

    // Basic scan of 1234 with all digits enabled.
    value_in = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    step(1'b1, 1'b0);
    run(70);

    // Reset held three cycles mid-scan, then rescan.
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run(40);

    // Font sweep on digit 0 with its decimal point lit.
    dp_in = 4'h1;
    for (int v = 0; v < 16; v++) begin
      value_in = 16'(v);
      step(1'b1, 1'b0);
      run(31);
    end

    // Leading-zero blanking.
    dp_in = 4'h0; lz_blank = 1'b1;
    value_in = 16'h0050; step(1'b1, 1'b0); run(40);
    value_in = 16'h0000; step(1'b1, 1'b0); run(40);
    lz_blank = 1'b0; run(40);

    // Partial enable, then a load landing mid-slot of digit 0.
    value_in = 16'h1234; digit_en = 4'b0101; step(1'b1, 1'b0);
    while ((k % (DIV * N)) != 4) run(1);
    value_in = 16'hFFFF; step(1'b1, 1'b0);
    run(40);

    // Randomized traffic with occasional loads and resets.
    for (int i = 0; i < 600; i++) begin
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 149) == 0) step(1'b0, 1'b1);
      else step(($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
